amiga_clk_ctrl: RTL

- Sits directly downstream of the Amiga clock generator, in the 28 MHz (c1) domain.
- Consumes the generator's asynchronous PLL/DLL lock indication.
- Sequences the system reset out of lock.
- Derives the chipset timing enables from the single 28 MHz clock: 7 MHz positive/negative enables, CCK phase and the 6-low/4-high E clock. All downstream chipset logic uses these enables instead of extra clock nets.

---
 rtl/amiga_clk_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/amiga_clk_ctrl.sv
// amiga_clk_ctrl: reset sequencer and chipset timing-enable generator for the 28 MHz (c1) domain.
//
// Synchronises the clock generator's lock flag, holds the system in reset until lock has been
// stable for RST_CYCLES clocks, then releases reset_out. From the single 28 MHz clock it derives
// the 7 MHz rising/falling enables, the 3.5 MHz colour clock level (cck) and the 6-low/4-high
// E clock (eclk) with its end-of-cycle enable (eclk_en).
//
// Build option: define AMIGA_CLK_CTRL_ECLK_EN to build the E clock logic. When it is not
// defined, eclk and eclk_en are tied low and no E counter exists.
//
// Parameters:
//   RST_CYCLES  clocks reset_out stays high after lock is seen stable (1..65535)
//   LOCK_SYNC   synchroniser depth on pll_locked (2..4)
//
// Ports:
//   clk         28 MHz system clock
//   reset_n     asynchronous active-low reset
//   pll_locked  lock flag from the clock generator, asynchronous to clk
//   soft_rst    synchronous request to re-run the reset sequence (honoured in RUN only)
//   reset_out   active-high registered system reset
//   clk7_en     1-clk pulse at 7 MHz, rising-edge phase
//   clk7n_en    1-clk pulse at 7 MHz, falling-edge phase
//   cck         colour clock level, toggles on each clk7_en
//   eclk        E clock level (high while the E count is 6..9)
//   eclk_en     1-clk pulse coincident with the clk7_en that ends an E cycle
//   running     high while in RUN

module amiga_clk_ctrl #(
    parameter int unsigned RST_CYCLES = 1024,
    parameter int unsigned LOCK_SYNC  = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_locked,
    input  logic soft_rst,
    output logic reset_out,
    output logic clk7_en,
    output logic clk7n_en,
    output logic cck,
    output logic eclk,
    output logic eclk_en,
    output logic running
);

    localparam logic [1:0]  ST_HOLD  = 2'd0;
    localparam logic [1:0]  ST_COUNT = 2'd1;
    localparam logic [1:0]  ST_RUN   = 2'd2;
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

    // ------------------------------------------------------------------
    // Lock synchroniser: the only place pll_locked is sampled.
    // ------------------------------------------------------------------
    logic [LOCK_SYNC-1:0] sync_q;
    logic                 lk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[LOCK_SYNC-2:0], pll_locked};
        end
    end

    assign lk = sync_q[LOCK_SYNC-1];

    // ------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [15:0] rst_cnt_q, rst_cnt_d;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            ST_HOLD: begin
                rst_cnt_d = '0;
                if (lk) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!lk) begin
                    state_d   = ST_HOLD;
                    rst_cnt_d = '0;
                end else if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_RUN;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 16'd1;
                end
            end
            ST_RUN: begin
                // Loss of lock wins over a soft reset request.
                if (!lk) begin
                    state_d   = ST_HOLD;
                    rst_cnt_d = '0;
                end else if (soft_rst) begin
                    state_d   = ST_COUNT;
                    rst_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_HOLD;
                rst_cnt_d = '0;
            end
        endcase
    end

    logic reset_out_q;
    logic running_q;

    // Outputs are registered from the next state so reset_out falls on the same edge the
    // sequencer enters RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HOLD;
            rst_cnt_q   <= '0;
            reset_out_q <= 1'b1;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            reset_out_q <= (state_d != ST_RUN);
            running_q   <= (state_d == ST_RUN);
        end
    end

    assign reset_out = reset_out_q;
    assign running   = running_q;

    // ------------------------------------------------------------------
    // 7 MHz phase and colour clock
    // ------------------------------------------------------------------
    // timing_on: the timing chain runs after this edge. Entering HOLD clears the chain and
    // suppresses every enable on that same edge; COUNT<->RUN leaves it untouched.
    logic       timing_on;
    logic [1:0] ph_q, ph_d;
    logic       clk7_en_q, clk7_en_d;
    logic       clk7n_en_q, clk7n_en_d;
    logic       cck_q, cck_d;

    always_comb begin
        timing_on  = (state_d != ST_HOLD);
        // ph stays at 0 on the HOLD->COUNT edge and starts counting on the next one.
        ph_d       = (timing_on && (state_q != ST_HOLD)) ? ph_q + 2'd1 : 2'd0;
        clk7_en_d  = timing_on && (ph_q == 2'd3);
        clk7n_en_d = timing_on && (ph_q == 2'd1);
        cck_d      = timing_on ? (cck_q ^ clk7_en_q) : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_q       <= 2'd0;
            clk7_en_q  <= 1'b0;
            clk7n_en_q <= 1'b0;
            cck_q      <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            clk7_en_q  <= clk7_en_d;
            clk7n_en_q <= clk7n_en_d;
            cck_q      <= cck_d;
        end
    end

    assign clk7_en  = clk7_en_q;
    assign clk7n_en = clk7n_en_q;
    assign cck      = cck_q;

    // ------------------------------------------------------------------
    // E clock: 10 clk7_en per cycle, low for counts 0..5, high for 6..9.
    // ------------------------------------------------------------------
`ifdef AMIGA_CLK_CTRL_ECLK_EN
    logic [3:0] e_cnt_q, e_cnt_d;
    logic       eclk_q, eclk_d;
    logic       eclk_en_q, eclk_en_d;

    always_comb begin
        e_cnt_d = e_cnt_q;
        if (!timing_on) begin
            e_cnt_d = 4'd0;
        end else if (clk7_en_q) begin
            // >= also recovers the unreachable codes 10..15.
            e_cnt_d = (e_cnt_q >= 4'd9) ? 4'd0 : e_cnt_q + 4'd1;
        end
        eclk_d    = (e_cnt_d >= 4'd6) && (e_cnt_d <= 4'd9);
        // clk7_en never fires on two consecutive clocks, so e_cnt_q is stable for the
        // whole cycle this pulse occupies.
        eclk_en_d = clk7_en_d && (e_cnt_q == 4'd9);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_cnt_q   <= 4'd0;
            eclk_q    <= 1'b0;
            eclk_en_q <= 1'b0;
        end else begin
            e_cnt_q   <= e_cnt_d;
            eclk_q    <= eclk_d;
            eclk_en_q <= eclk_en_d;
        end
    end

    assign eclk    = eclk_q;
    assign eclk_en = eclk_en_q;
`else
    assign eclk    = 1'b0;
    assign eclk_en = 1'b0;
`endif

endmodule
